branch_jump_unit: RTL and testbench

Execution stage directly downstream of the branch/jump reservation station. Accepts one issued branch or jump per cycle as the 112-bit issue bundle, resolves taken/not-taken and the target, and broadcasts the result on a dedicated common-data-bus port under request/grant arbitration. Decode predicts not-taken, so every taken branch and every jump raises a one-cycle `kill` plus `redirect_pc` to flush speculative state.

---
 rtl/branch_jump_unit.sv | 133 +++++++++++++
 tb/tb_branch_jump_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_jump_unit.sv
// Two-stage branch/jump execution unit: resolves taken/target for one issued
// branch or jump per cycle, broadcasts the result on a CDB port and flushes on taken.
module branch_jump_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic         ex_en,
    input  logic [111:0] rs2exe,
    output logic         ex_ready,
    input  logic         cdb_grant,
    output logic         cdb_req,
    output logic [37:0]  cdb_out,
    output logic         kill,
    output logic [31:0]  redirect_pc
);

    typedef struct packed {
        logic [9:0]  instType;
        logic [5:0]  dest;
        logic [31:0] opr1;
        logic [31:0] opr2;
        logic [31:0] addr;
    } issue_t;

    logic        s1ValidQ, s1ValidD;
    issue_t      s1BundleQ, s1BundleD;
    logic        s2ValidQ, s2ValidD;
    logic        s2TakenQ, s2TakenD;
    logic [5:0]  s2DestQ, s2DestD;
    logic [31:0] s2ValueQ, s2ValueD;
    logic [31:0] s2TargetQ, s2TargetD;

    logic        s2Leaving;
    logic        killW;
    logic        s1Advance;
    logic        accept;

    logic        oprEq;
    logic        oprLtSigned;
    logic        oprLtUnsigned;
    logic        brTaken;
    logic        resTaken;
    logic [31:0] resValue;
    logic [31:0] resTarget;

    // Resolve the S1 instruction; reserved or empty types fall out as not-taken with value 0.
    always_comb begin
        oprEq         = (s1BundleQ.opr1 == s1BundleQ.opr2);
        oprLtSigned   = ($signed(s1BundleQ.opr1) < $signed(s1BundleQ.opr2));
        oprLtUnsigned = (s1BundleQ.opr1 < s1BundleQ.opr2);
        brTaken       = (s1BundleQ.instType[2] &  oprEq)
                      | (s1BundleQ.instType[3] & ~oprEq)
                      | (s1BundleQ.instType[4] &  oprLtSigned)
                      | (s1BundleQ.instType[5] & ~oprLtSigned)
                      | (s1BundleQ.instType[6] &  oprLtUnsigned)
                      | (s1BundleQ.instType[7] & ~oprLtUnsigned);
        resTaken  = brTaken;
        resValue  = {31'b0, brTaken};
        resTarget = s1BundleQ.addr;
        if (s1BundleQ.instType[0]) begin
            resTaken  = 1'b1;
            resValue  = s1BundleQ.opr1;
            resTarget = s1BundleQ.addr;
        end else if (s1BundleQ.instType[1]) begin
            resTaken  = 1'b1;
            resValue  = s1BundleQ.opr2;
            resTarget = (s1BundleQ.opr1 + s1BundleQ.addr) & ~32'h1;
        end
    end

    // A kill squashes the younger S1 entry and blocks capture in the same cycle.
    always_comb begin
        s2Leaving = s2ValidQ & cdb_grant;
        killW     = s2Leaving & s2TakenQ;
        s1Advance = s1ValidQ & (~s2ValidQ | s2Leaving) & ~killW;
        ex_ready  = ~killW & (~s1ValidQ | s1Advance);
        accept    = ex_en & ex_ready;
    end

    always_comb begin
        s1ValidD  = s1ValidQ;
        s1BundleD = s1BundleQ;
        s2ValidD  = s2ValidQ;
        s2TakenD  = s2TakenQ;
        s2DestD   = s2DestQ;
        s2ValueD  = s2ValueQ;
        s2TargetD = s2TargetQ;

        if (killW) begin
            s1ValidD = 1'b0;
        end else if (accept) begin
            s1ValidD  = 1'b1;
            s1BundleD = issue_t'(rs2exe);
        end else if (s1Advance) begin
            s1ValidD = 1'b0;
        end

        if (s1Advance) begin
            s2ValidD  = 1'b1;
            s2TakenD  = resTaken;
            s2DestD   = s1BundleQ.dest;
            s2ValueD  = resValue;
            s2TargetD = resTarget;
        end else if (s2Leaving) begin
            s2ValidD = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1ValidQ  <= 1'b0;
            s1BundleQ <= '0;
            s2ValidQ  <= 1'b0;
            s2TakenQ  <= 1'b0;
            s2DestQ   <= '0;
            s2ValueQ  <= '0;
            s2TargetQ <= '0;
        end else begin
            s1ValidQ  <= s1ValidD;
            s1BundleQ <= s1BundleD;
            s2ValidQ  <= s2ValidD;
            s2TakenQ  <= s2TakenD;
            s2DestQ   <= s2DestD;
            s2ValueQ  <= s2ValueD;
            s2TargetQ <= s2TargetD;
        end
    end

    assign cdb_req     = s2ValidQ;
    assign cdb_out     = s2ValidQ ? {s2DestQ, s2ValueQ} : 38'd0;
    assign kill        = killW;
    assign redirect_pc = killW ? s2TargetQ : 32'd0;

endmodule

// File: tb/tb_branch_jump_unit.sv
// Scoreboard bench for branch_jump_unit: a driver pushes expected results on accept,
// a negedge monitor checks handshake, CDB word, kill and redirect against an in-order model.
module tb_branch_jump_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         ex_en;
    logic [111:0] rs2exe;
    logic         ex_ready;
    logic         cdb_grant;
    logic         cdb_req;
    logic [37:0]  cdb_out;
    logic         kill;
    logic [31:0]  redirect_pc;

    branch_jump_unit dut (
        .clk         (clk),
        .reset       (reset),
        .ex_en       (ex_en),
        .rs2exe      (rs2exe),
        .ex_ready    (ex_ready),
        .cdb_grant   (cdb_grant),
        .cdb_req     (cdb_req),
        .cdb_out     (cdb_out),
        .kill        (kill),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  dest;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
        int          acc;
    } exp_t;

    exp_t         sb[$];
    logic [111:0] toIssue[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           lastLeave = -10;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour straight from the instruction semantics.
    function automatic exp_t refModel(input logic [111:0] b);
        exp_t        e;
        logic [9:0]  t;
        logic [31:0] a;
        logic [31:0] o;
        logic [31:0] ad;
        t  = b[111:102];
        a  = b[95:64];
        o  = b[63:32];
        ad = b[31:0];
        e.dest   = b[101:96];
        e.acc    = 0;
        e.target = ad;
        if (t == 10'd1) begin
            e.taken = 1'b1;
            e.value = a;
        end else if (t == 10'd2) begin
            e.taken  = 1'b1;
            e.value  = o;
            e.target = (a + ad) & 32'hFFFF_FFFE;
        end else begin
            case (t)
                10'd4:   e.taken = (a == o);
                10'd8:   e.taken = (a != o);
                10'd16:  e.taken = ($signed(a) <  $signed(o));
                10'd32:  e.taken = ($signed(a) >= $signed(o));
                10'd64:  e.taken = (a <  o);
                10'd128: e.taken = (a >= o);
                default: e.taken = 1'b0;
            endcase
            e.value = e.taken ? 32'd1 : 32'd0;
        end
        return e;
    endfunction

    function automatic logic [111:0] mk(input logic [9:0] t, input logic [5:0] d,
                                        input logic [31:0] a, input logic [31:0] o,
                                        input logic [31:0] ad);
        return {t, d, a, o, ad};
    endfunction

    function automatic logic [111:0] randBundle();
        int          k;
        logic [9:0]  t;
        logic [31:0] a;
        logic [31:0] o;
        k = $urandom_range(0, 10);
        t = (k == 10) ? 10'd0 : 10'(1 << k);
        a = $urandom;
        case ($urandom_range(0, 3))
            0:       o = a;
            1:       o = a ^ 32'h8000_0000;
            default: o = $urandom;
        endcase
        return mk(t, 6'($urandom_range(0, 63)), a, o, $urandom);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // gMode: 0 grant low, 1 grant high, 2 random grant; enPct: chance to present a pending issue.
    task automatic applyStimulus(input int n, input int gMode, input int enPct);
        logic [127:0] junk;
        exp_t         e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cdb_grant = (gMode == 0) ? 1'b0 : (gMode == 1) ? 1'b1 : ($urandom_range(0, 99) < 70);
            if (toIssue.size() > 0 && $urandom_range(0, 99) < enPct) begin
                ex_en  = 1'b1;
                rs2exe = toIssue[0];
            end else begin
                junk   = {$urandom, $urandom, $urandom, $urandom};
                ex_en  = 1'b0;
                rs2exe = junk[111:0];
            end
            #2;
            if (ex_en && ex_ready && !reset) begin
                e     = refModel(toIssue[0]);
                e.acc = cyc;
                sb.push_back(e);
                void'(toIssue.pop_front());
            end
        end
    endtask

    task automatic doReset(input int n);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        ex_en     = 1'b0;
        cdb_grant = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: an entry reaches the CDB two cycles after accept, or the cycle after its predecessor left.
    initial begin
        int   nOld;
        int   rdy;
        logic presented;
        logic leaving;
        logic killExp;
        logic expReady;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                lastLeave = -10;
                continue;
            end
            nOld = 0;
            foreach (sb[i]) if (sb[i].acc < cyc) nOld++;
            presented = 1'b0;
            if (nOld > 0) begin
                rdy = sb[0].acc + 2;
                if (lastLeave + 1 > rdy) rdy = lastLeave + 1;
                presented = (cyc >= rdy);
            end
            leaving  = presented && cdb_grant;
            killExp  = leaving && sb[0].taken;
            expReady = !killExp && (nOld < 2 || leaving);
            checkOutput("ex_ready", 64'(ex_ready), 64'(expReady));
            checkOutput("cdb_req", 64'(cdb_req), 64'(presented));
            checkOutput("kill", 64'(kill), 64'(killExp));
            checkOutput("redirect_pc", 64'(redirect_pc), killExp ? 64'(sb[0].target) : 64'd0);
            checkOutput("cdb_out", 64'(cdb_out), presented ? 64'({sb[0].dest, sb[0].value}) : 64'd0);
            if (leaving) begin
                void'(sb.pop_front());
                lastLeave = cyc;
                if (killExp) sb.delete();
            end
        end
    end

    initial begin
        int guard;
        reset     = 1'b1;
        ex_en     = 1'b0;
        cdb_grant = 1'b0;
        rs2exe    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(2, 1, 100);

        toIssue.push_back(mk(10'd4, 6'd3, 32'd5, 32'd5, 32'h100));
        applyStimulus(5, 1, 100);
        toIssue.push_back(mk(10'd16, 6'd7, 32'hFFFF_FFFF, 32'd1, 32'h200));
        toIssue.push_back(mk(10'd64, 6'd8, 32'hFFFF_FFFF, 32'd1, 32'h300));
        applyStimulus(8, 1, 100);
        toIssue.push_back(mk(10'd2, 6'd9, 32'h1003, 32'h2004, 32'h4));
        toIssue.push_back(mk(10'd1, 6'd10, 32'h44, 32'h0, 32'h800));
        toIssue.push_back(mk(10'h200, 6'd11, 32'd1, 32'd1, 32'h900));
        toIssue.push_back(mk(10'd0, 6'd12, 32'd2, 32'd2, 32'hA00));
        applyStimulus(12, 1, 100);

        toIssue.push_back(mk(10'd8, 6'd13, 32'd4, 32'd4, 32'h10));
        toIssue.push_back(mk(10'd128, 6'd14, 32'd1, 32'd9, 32'h20));
        toIssue.push_back(mk(10'd32, 6'd15, 32'h8000_0000, 32'd0, 32'h30));
        applyStimulus(5, 0, 100);
        applyStimulus(6, 1, 100);

        toIssue.push_back(mk(10'd4, 6'd16, 32'd1, 32'd1, 32'h4000));
        toIssue.push_back(mk(10'd8, 6'd17, 32'd2, 32'd2, 32'h5000));
        toIssue.push_back(mk(10'd64, 6'd18, 32'd9, 32'd3, 32'h6000));
        applyStimulus(3, 0, 100);
        applyStimulus(6, 1, 100);

        toIssue.push_back(mk(10'd1, 6'd19, 32'h8, 32'h0, 32'h7000));
        toIssue.push_back(mk(10'd3 << 2, 6'd20, 32'd0, 32'd0, 32'h0));
        toIssue.delete();
        toIssue.push_back(mk(10'd1, 6'd19, 32'h8, 32'h0, 32'h7000));
        toIssue.push_back(mk(10'd8, 6'd20, 32'd3, 32'd3, 32'h0));
        applyStimulus(4, 0, 100);
        doReset(1);
        applyStimulus(3, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if (toIssue.size() < 2) toIssue.push_back(randBundle());
            applyStimulus(1, 2, 75);
            if (i == 300) doReset(1);
        end

        guard = 0;
        while ((toIssue.size() > 0 || sb.size() > 0) && guard < 100) begin
            applyStimulus(1, 1, 100);
            guard++;
        end
        @(negedge clk);
        checkOutput("drain_outstanding", 64'(sb.size() + toIssue.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
